// File: rtl/baser_257b_transcoder.sv
// Transmit-side 256b/257b transcoder: gathers four 66b blocks from a
// valid/ready stream and emits one 257b transcoded block, with statistics.
module baser_257b_transcoder #(
  parameter int         DATA_WIDTH     = 64,
  parameter int         HDR_WIDTH      = 2,
  parameter int         FRAME_WIDTH    = 66,
  parameter int         TC_WIDTH       = 257,
  parameter logic [7:0] ERR_BLOCK_TYPE = 8'h1E,
  parameter logic [6:0] ERR_CHAR       = 7'h1E
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [FRAME_WIDTH-1:0] i_tx_coded,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [TC_WIDTH-1:0]    o_tx_xcoded,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_err,
  output logic [31:0]            o_block_count,
  output logic [31:0]            o_data_count,
  output logic [31:0]            o_ctrl_count,
  output logic [31:0]            o_inv_block_count
);

  localparam logic [HDR_WIDTH-1:0] HDR_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {IDX0, IDX1, IDX2, IDX3} idx_t;

  idx_t                  idx_q, idx_d;
  logic [HDR_WIDTH-1:0]  hdr_in;
  logic [DATA_WIDTH-1:0] pay_in;
  logic                  is_data_in, is_inv_in;
  logic                  accept, load;
  logic [DATA_WIDTH-1:0] slot_pay [3];
  logic [2:0]            slot_data, slot_inv;
  logic [TC_WIDTH-1:0]   xcoded_nxt;
  logic [TC_WIDTH-1:0]   xcoded_p1;
  logic                  vld_p1, err_p1;
  logic [31:0]           block_cnt, data_cnt, ctrl_cnt, inv_cnt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // 257b packing: all-data words keep the four payloads whole behind a 1 header;
  // otherwise a 0 header, the data-flag nibble, then blocks 0..3 LSB-first where the
  // first control block loses its low type nibble to make room for the flags.
  function automatic logic [TC_WIDTH-1:0] transcode(
    input logic [DATA_WIDTH-1:0] p0, input logic [DATA_WIDTH-1:0] p1,
    input logic [DATA_WIDTH-1:0] p2, input logic [DATA_WIDTH-1:0] p3,
    input logic [3:0] d);
    logic [TC_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0] p [4];
    int                    first_c;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    acc = '0;
    if (&d) begin
      acc = {p3, p2, p1, p0, 1'b1};
    end else begin
      first_c = 0;
      for (int n = 3; n >= 0; n--)
        if (!d[n]) first_c = n;
      for (int n = 3; n >= 0; n--) begin
        if (n == first_c)
          acc = (acc << 60) | TC_WIDTH'({p[n][DATA_WIDTH-1:8], p[n][7:4]});
        else
          acc = (acc << DATA_WIDTH) | TC_WIDTH'(p[n]);
      end
      acc = (acc << 5) | TC_WIDTH'({d, 1'b0});
    end
    return acc;
  endfunction

  assign hdr_in     = i_tx_coded[HDR_WIDTH-1:0];
  assign is_data_in = (hdr_in == HDR_DATA);
  assign is_inv_in  = (hdr_in != HDR_DATA) && (hdr_in != HDR_CTRL);
  assign pay_in     = is_inv_in ? {{8{ERR_CHAR}}, ERR_BLOCK_TYPE}
                                : i_tx_coded[FRAME_WIDTH-1:HDR_WIDTH];
  assign xcoded_nxt = transcode(slot_pay[0], slot_pay[1], slot_pay[2], pay_in,
                                {is_data_in, slot_data});

  // Collector index register.
  always_ff @(posedge clk) begin
    if (i_rst) idx_q <= IDX0;
    else       idx_q <= idx_d;
  end

  // Handshake and next index: only the 4th block waits on a full output register.
  always_comb begin
    idx_d   = idx_q;
    o_ready = (idx_q != IDX3) || !vld_p1 || i_ready;
    accept  = i_valid && o_ready;
    load    = accept && (idx_q == IDX3);
    if (accept) begin
      case (idx_q)
        IDX0:    idx_d = IDX1;
        IDX1:    idx_d = IDX2;
        IDX2:    idx_d = IDX3;
        default: idx_d = IDX0;
      endcase
    end
  end

  // Slot storage for blocks 0..2; block 3 is consumed live from the input.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (idx_q)
        IDX0: begin slot_pay[0] <= pay_in; slot_data[0] <= is_data_in; slot_inv[0] <= is_inv_in; end
        IDX1: begin slot_pay[1] <= pay_in; slot_data[1] <= is_data_in; slot_inv[1] <= is_inv_in; end
        IDX2: begin slot_pay[2] <= pay_in; slot_data[2] <= is_data_in; slot_inv[2] <= is_inv_in; end
        default: ;
      endcase
    end
  end

  // ---- stage p1: output register and statistics ----
  // Output word is held until taken; a reload in the same cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      vld_p1    <= 1'b0;
      xcoded_p1 <= '0;
      err_p1    <= 1'b0;
      block_cnt <= '0;
      data_cnt  <= '0;
      ctrl_cnt  <= '0;
      inv_cnt   <= '0;
    end else begin
      if (load) begin
        vld_p1    <= 1'b1;
        xcoded_p1 <= xcoded_nxt;
        err_p1    <= is_inv_in | (|slot_inv);
        block_cnt <= sat_inc(block_cnt);
        if (is_data_in && (&slot_data)) data_cnt <= sat_inc(data_cnt);
        else                            ctrl_cnt <= sat_inc(ctrl_cnt);
      end else if (i_ready) begin
        vld_p1 <= 1'b0;
      end
      if (accept && is_inv_in) inv_cnt <= sat_inc(inv_cnt);
    end
  end

  assign o_tx_xcoded       = xcoded_p1;
  assign o_valid           = vld_p1;
  assign o_err             = err_p1;
  assign o_block_count     = block_cnt;
  assign o_data_count      = data_cnt;
  assign o_ctrl_count      = ctrl_cnt;
  assign o_inv_block_count = inv_cnt;

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Testbench for baser_257b_transcoder: directed scenarios plus a randomized
// stream, all checked against a bit-list reference model of the transcoding.
module tb_baser_257b_transcoder;

  logic         clk;
  logic         i_rst;
  logic [65:0]  i_tx_coded;
  logic         i_valid;
  logic         o_ready;
  logic [256:0] o_tx_xcoded;
  logic         o_valid;
  logic         i_ready;
  logic         o_err;
  logic [31:0]  o_block_count, o_data_count, o_ctrl_count, o_inv_block_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int           m_idx;
  logic [63:0]  m_pay [4];
  bit           m_dat [4];
  bit           m_inv [4];
  logic         m_valid;
  logic [256:0] m_word;
  logic         m_err;
  logic [31:0]  m_blk, m_data, m_ctrl, m_invc;

  localparam logic [63:0] AA   = {8{8'hAA}};
  localparam logic [63:0] ERRP = {{8{7'h1E}}, 8'h1E};

  baser_257b_transcoder dut (
    .clk(clk), .i_rst(i_rst), .i_tx_coded(i_tx_coded), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx_xcoded(o_tx_xcoded), .o_valid(o_valid),
    .i_ready(i_ready), .o_err(o_err), .o_block_count(o_block_count),
    .o_data_count(o_data_count), .o_ctrl_count(o_ctrl_count),
    .o_inv_block_count(o_inv_block_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Build the 257b word as a list of bits appended LSB-first.
  function automatic logic [256:0] model_xcode();
    bit           q[$];
    logic [256:0] r;
    bit           seen_ctrl;
    int           lo;
    r = '0;
    if (m_dat[0] && m_dat[1] && m_dat[2] && m_dat[3]) begin
      r = {m_pay[3], m_pay[2], m_pay[1], m_pay[0], 1'b1};
    end else begin
      q.push_back(1'b0);
      for (int n = 0; n < 4; n++) q.push_back(m_dat[n]);
      seen_ctrl = 0;
      for (int n = 0; n < 4; n++) begin
        lo = 0;
        if (!m_dat[n] && !seen_ctrl) begin lo = 4; seen_ctrl = 1; end
        for (int b = lo; b < 64; b++) q.push_back(m_pay[n][b]);
      end
      for (int i = 0; i < 257; i++) r[i] = q[i];
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_valid = 0; m_word = '0; m_err = 0;
    m_blk = 0; m_data = 0; m_ctrl = 0; m_invc = 0;
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // One clock: drive at the falling edge, compare all outputs to the model,
  // advance the model across the rising edge, return to the falling edge.
  task automatic step(input logic v, input logic [65:0] blk, input logic rdy,
                      input logic rst, output logic acc);
    logic exp_rdy, ld;
    logic [1:0] h;
    i_valid = v; i_tx_coded = blk; i_ready = rdy; i_rst = rst;
    #1;
    exp_rdy = (m_idx != 3) || !m_valid || rdy;
    chk_cnt++; if (o_ready !== exp_rdy) $display("FAIL o_ready: got %b want %b", o_ready, exp_rdy); else pass_cnt++;
    chk_cnt++; if (o_valid !== m_valid) $display("FAIL o_valid: got %b want %b", o_valid, m_valid); else pass_cnt++;
    chk_cnt++; if (o_tx_xcoded !== m_word) $display("FAIL o_tx_xcoded: got %h want %h", o_tx_xcoded, m_word); else pass_cnt++;
    chk_cnt++; if (o_err !== m_err) $display("FAIL o_err: got %b want %b", o_err, m_err); else pass_cnt++;
    chk_cnt++; if (o_block_count !== m_blk) $display("FAIL block_count: got %0d want %0d", o_block_count, m_blk); else pass_cnt++;
    chk_cnt++; if (o_data_count !== m_data) $display("FAIL data_count: got %0d want %0d", o_data_count, m_data); else pass_cnt++;
    chk_cnt++; if (o_ctrl_count !== m_ctrl) $display("FAIL ctrl_count: got %0d want %0d", o_ctrl_count, m_ctrl); else pass_cnt++;
    chk_cnt++; if (o_inv_block_count !== m_invc) $display("FAIL inv_block_count: got %0d want %0d", o_inv_block_count, m_invc); else pass_cnt++;
    acc = v && exp_rdy && !rst;
    if (rst) begin
      model_reset();
    end else begin
      ld = 0;
      if (acc) begin
        h = blk[1:0];
        m_dat[m_idx] = (h == 2'b01);
        m_inv[m_idx] = (h == 2'b00) || (h == 2'b11);
        m_pay[m_idx] = m_inv[m_idx] ? ERRP : blk[65:2];
        if (m_inv[m_idx]) m_invc = sat1(m_invc);
        m_idx++;
        if (m_idx == 4) begin
          ld = 1; m_idx = 0;
          m_word = model_xcode();
          m_err = m_inv[0] | m_inv[1] | m_inv[2] | m_inv[3];
          m_blk = sat1(m_blk);
          if (m_dat[0] && m_dat[1] && m_dat[2] && m_dat[3]) m_data = sat1(m_data);
          else m_ctrl = sat1(m_ctrl);
        end
      end
      if (ld) m_valid = 1; else if (rdy) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_block(input logic [65:0] blk, input logic rdy);
    logic acc;
    int n;
    acc = 0; n = 0;
    while (!acc && n < 16) begin step(1'b1, blk, rdy, 1'b0, acc); n++; end
    chk_cnt++;
    if (!acc) $display("FAIL send_block: accepted=%b after %0d cycles, want 1", acc, n); else pass_cnt++;
  endtask

  task automatic test_reset();
    i_rst = 1; i_valid = 0; i_ready = 0; i_tx_coded = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL reset o_valid: got %b want 0", o_valid); else pass_cnt++;
    chk_cnt++; if (o_tx_xcoded !== '0) $display("FAIL reset o_tx_xcoded: got %h want 0", o_tx_xcoded); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL reset o_err: got %b want 0", o_err); else pass_cnt++;
    chk_cnt++; if ({o_block_count, o_data_count, o_ctrl_count, o_inv_block_count} !== '0)
      $display("FAIL reset counters: got %h want 0", {o_block_count, o_data_count, o_ctrl_count, o_inv_block_count}); else pass_cnt++;
    chk_cnt++; if (o_ready !== 1'b1) $display("FAIL reset o_ready: got %b want 1", o_ready); else pass_cnt++;
    model_reset();
    i_rst = 0;
  endtask

  task automatic test_all_data();
    for (int i = 0; i < 4; i++) send_block({AA, 2'b01}, 1'b1);
    chk_cnt++; if (o_valid !== 1'b1) $display("FAIL all_data valid: got %b want 1", o_valid); else pass_cnt++;
    chk_cnt++; if (o_tx_xcoded !== {{32{8'hAA}}, 1'b1}) $display("FAIL all_data word: got %h want %h", o_tx_xcoded, {{32{8'hAA}}, 1'b1}); else pass_cnt++;
    chk_cnt++; if (o_data_count !== 32'd1) $display("FAIL all_data data_count: got %0d want 1", o_data_count); else pass_cnt++;
  endtask

  task automatic test_start_first();
    logic [256:0] w;
    logic [31:0] c0;
    c0 = m_ctrl;
    send_block({{7{8'hAA}}, 8'h78, 2'b10}, 1'b1);
    for (int i = 0; i < 3; i++) send_block({AA, 2'b01}, 1'b1);
    w = o_tx_xcoded;
    chk_cnt++; if (w[4:1] !== 4'b1110) $display("FAIL start_first flags: got %b want 1110", w[4:1]); else pass_cnt++;
    chk_cnt++; if (w[8:5] !== 4'h7) $display("FAIL start_first nibble: got %h want 7", w[8:5]); else pass_cnt++;
    chk_cnt++; if (w[64:9] !== {7{8'hAA}}) $display("FAIL start_first blk0: got %h want %h", w[64:9], {7{8'hAA}}); else pass_cnt++;
    chk_cnt++; if (w[256:65] !== {24{8'hAA}}) $display("FAIL start_first blk1_3: got %h want %h", w[256:65], {24{8'hAA}}); else pass_cnt++;
    chk_cnt++; if (o_ctrl_count !== c0 + 1) $display("FAIL start_first ctrl_count: got %0d want %0d", o_ctrl_count, c0 + 1); else pass_cnt++;
  endtask

  task automatic test_mixed();
    logic [256:0] w;
    send_block({AA, 2'b01}, 1'b1);
    send_block({{7{8'hAA}}, 8'hFF, 2'b10}, 1'b1);
    send_block({AA, 2'b01}, 1'b1);
    send_block({{8{7'h1E}}, 8'h87, 2'b10}, 1'b1);
    w = o_tx_xcoded;
    chk_cnt++; if (w[4:1] !== 4'b0101) $display("FAIL mixed flags: got %b want 0101", w[4:1]); else pass_cnt++;
    chk_cnt++; if (w[72:69] !== 4'hF) $display("FAIL mixed nibble: got %h want F", w[72:69]); else pass_cnt++;
    chk_cnt++; if (w[200:193] !== 8'h87) $display("FAIL mixed type3: got %h want 87", w[200:193]); else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [256:0] w;
    logic [31:0] c0;
    c0 = m_invc;
    send_block({AA, 2'b01}, 1'b1);
    send_block({AA, 2'b01}, 1'b1);
    send_block({64'h0123_4567_89AB_CDEF, 2'b11}, 1'b1);
    send_block({AA, 2'b01}, 1'b1);
    w = o_tx_xcoded;
    chk_cnt++; if (w[4:1] !== 4'b1011) $display("FAIL invalid flags: got %b want 1011", w[4:1]); else pass_cnt++;
    chk_cnt++; if (w[192:133] !== {{8{7'h1E}}, 4'h1}) $display("FAIL invalid blk2: got %h want %h", w[192:133], {{8{7'h1E}}, 4'h1}); else pass_cnt++;
    chk_cnt++; if (o_err !== 1'b1) $display("FAIL invalid o_err: got %b want 1", o_err); else pass_cnt++;
    chk_cnt++; if (o_inv_block_count !== c0 + 1) $display("FAIL invalid inv_count: got %0d want %0d", o_inv_block_count, c0 + 1); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [256:0] w1;
    step(1'b0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 7; i++) send_block({{$urandom, $urandom}, 2'b01}, 1'b0);
    w1 = m_word;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, {AA, 2'b10}, 1'b0, 1'b0, acc);
      chk_cnt++; if (acc !== 1'b0) $display("FAIL bp stall: accepted=%b want 0", acc); else pass_cnt++;
      chk_cnt++; if (o_tx_xcoded !== w1) $display("FAIL bp hold: got %h want %h", o_tx_xcoded, w1); else pass_cnt++;
    end
    send_block({AA, 2'b10}, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk_cnt++; if (o_block_count !== 32'd2) $display("FAIL bp block_count: got %0d want 2", o_block_count); else pass_cnt++;
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL bp drained: o_valid=%b want 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [63:0] p [4];
    send_block({64'hDEAD_BEEF_0000_0001, 2'b10}, 1'b1);
    send_block({64'hDEAD_BEEF_0000_0002, 2'b00}, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk_cnt++; if ({o_valid, o_err, o_tx_xcoded} !== '0) $display("FAIL rst_mid outputs: got %h want 0", {o_valid, o_err, o_tx_xcoded}); else pass_cnt++;
    chk_cnt++; if ({o_block_count, o_data_count, o_ctrl_count, o_inv_block_count} !== '0)
      $display("FAIL rst_mid counters: got %h want 0", {o_block_count, o_data_count, o_ctrl_count, o_inv_block_count}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      p[i] = {$urandom, $urandom};
      send_block({p[i], 2'b01}, 1'b1);
    end
    chk_cnt++; if (o_tx_xcoded !== {p[3], p[2], p[1], p[0], 1'b1}) $display("FAIL rst_mid fresh word: got %h want %h", o_tx_xcoded, {p[3], p[2], p[1], p[0], 1'b1}); else pass_cnt++;
    chk_cnt++; if (o_block_count !== 32'd1) $display("FAIL rst_mid block_count: got %0d want 1", o_block_count); else pass_cnt++;
  endtask

  task automatic test_random();
    logic acc;
    logic [1:0] h;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      h = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
      step(($urandom_range(0, 4) != 0), {{$urandom, $urandom}, h},
           ($urandom_range(0, 9) < 6), 1'b0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    test_reset();
    test_all_data();
    test_start_first();
    test_mixed();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
